// File: rtl/gpioemu_mul_unit.sv
// gpioemu_mul_unit: bus-mapped serial shift-add multiplier with popcount and op counter.
// Optional OVF_SATURATE_EN: on overflow W saturates to all ones and L = RES_W.
module gpioemu_mul_unit #(
  parameter int OP_W = 24,
  parameter int RES_W = 32,
  parameter logic [15:0] BASE_ADDR = 16'h0380,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [15:0] saddress,
  input  logic        srd,
  input  logic        swr,
  input  logic [31:0] sdata_in,
  output logic [31:0] sdata_out,
  input  logic [31:0] gpio_in,
  input  logic        gpio_latch,
  output logic [31:0] gpio_in_s_insp,
  output logic [31:0] gpio_out
);
  localparam int AW = 2 * OP_W;
  localparam int LW = $clog2(RES_W + 1);
  localparam int IW = $clog2(OP_W);
  typedef enum logic [1:0] {IDLE, MULT, COUNT, DONE} state_t;
  state_t state, state_n;
  logic srd_q, swr_q, lt_q, rd_p, wr_p, v, ok, start;
  logic [15:0] addr_q, off;
  logic [31:0] din_q, rdata, gpio_in_s;
  logic [OP_W-1:0] a1, a2, b;
  logic [AW-1:0] acc, m;
  logic [IW-1:0] idx;
  logic [RES_W-1:0] w, w_n;
  logic [LW-1:0] l, l_n;
  logic [1:0] status;
  logic [CNT_W-1:0] op_count;
  logic unused_bits;
  assign unused_bits = ^din_q;
  assign off = addr_q - BASE_ADDR;
  assign start = wr_p && off == 16'h20;
  assign gpio_out = 32'(op_count);
  assign gpio_in_s_insp = gpio_in_s;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = MULT;
      MULT:    if (idx == IW'(OP_W - 1)) state_n = COUNT;
      COUNT:   state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    ok = (acc >> RES_W) == '0;
    w_n = acc[RES_W-1:0];
    l_n = '0;
    for (int i = 0; i < RES_W; i++) l_n = l_n + LW'(w_n[i]);
`ifdef OVF_SATURATE_EN
    w_n = ok ? w_n : '1;
    l_n = ok ? l_n : LW'(RES_W);
`endif
  end
  // W is hidden while an operation is in flight
  always_comb
    rdata = off == 16'h00 ? 32'(a1) :
            off == 16'h08 ? 32'(a2) :
            off == 16'h10 ? (state == IDLE ? 32'(w) : 32'h0) :
            off == 16'h18 ? 32'(l) :
            off == 16'h20 ? {30'b0, status} : 32'h0;
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) begin
      state <= IDLE;
      {srd_q, swr_q, lt_q, rd_p, wr_p, v} <= '0;
      addr_q <= '0;
      din_q <= '0;
      sdata_out <= '0;
      gpio_in_s <= '0;
      {a1, a2, b, acc, m, idx, w, l, op_count} <= '0;
      status <= 2'b11;
    end else begin
      srd_q <= srd;
      swr_q <= swr;
      lt_q <= gpio_latch;
      rd_p <= srd & ~srd_q;
      wr_p <= swr & ~swr_q;
      addr_q <= saddress;
      din_q <= sdata_in;
      state <= state_n;
      if (gpio_latch & ~lt_q) gpio_in_s <= gpio_in;
      if (wr_p && off == 16'h00) a1 <= din_q[OP_W-1:0];
      if (wr_p && off == 16'h08) a2 <= din_q[OP_W-1:0];
      if (rd_p) sdata_out <= rdata;
      case (state)
        IDLE: if (start) begin
          m <= AW'(a1);
          b <= a2;
          acc <= '0;
          idx <= '0;
          status <= 2'b01;
        end
        MULT: begin
          acc <= acc + (b[0] ? m : '0);
          m <= m << 1;
          b <= b >> 1;
          idx <= idx + 1'b1;
        end
        COUNT: begin
          w <= w_n;
          l <= l_n;
          v <= ok;
        end
        default: begin
          status <= {1'b1, v};
          op_count <= op_count + 1'b1;
        end
      endcase
    end
endmodule

// File: tb/tb_gpioemu_mul_unit.sv
// tb_gpioemu_mul_unit: directed vectors, read responses checked by a queue-based monitor.
module tb_gpioemu_mul_unit;
  localparam int OP_W = 24;
  localparam logic [15:0] A1 = 16'h0380, A2 = 16'h0388, RW = 16'h0390, RL = 16'h0398, CT = 16'h03A0;
  logic clk = 0, n_reset = 0, srd = 0, swr = 0, gpio_latch = 0;
  logic [15:0] saddress = 0;
  logic [31:0] sdata_in = 0, gpio_in = 0;
  logic [31:0] sdata_out, gpio_in_s_insp, gpio_out;
  int checks = 0, failures = 0;
  logic [31:0] exp_q[$];
  string name_q[$];
  gpioemu_mul_unit dut (
    .clk(clk), .n_reset(n_reset), .saddress(saddress), .srd(srd), .swr(swr),
    .sdata_in(sdata_in), .sdata_out(sdata_out), .gpio_in(gpio_in),
    .gpio_latch(gpio_latch), .gpio_in_s_insp(gpio_in_s_insp), .gpio_out(gpio_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask
  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    saddress = a;
    sdata_in = d;
    swr = 1;
    @(negedge clk);
    swr = 0;
  endtask
  task automatic rd(input logic [15:0] a, input logic [31:0] e, input string n);
    exp_q.push_back(e);
    name_q.push_back(n);
    @(negedge clk);
    saddress = a;
    srd = 1;
    @(negedge clk);
    srd = 0;
    repeat (2) @(negedge clk);
  endtask
  initial begin
    logic p;
    p = 0;
    forever begin
      @(posedge clk);
      if (srd && !p && n_reset) begin
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_read got=%h", sdata_out);
        end else chk(name_q.pop_front(), sdata_out, exp_q.pop_front());
      end
      p = srd;
    end
  end
  initial begin
    #200000;
    $display("FAIL timeout");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    n_reset = 1;
    @(negedge clk);
    chk("rst_gpio_out", gpio_out, 0);
    chk("rst_insp", gpio_in_s_insp, 0);
    rd(CT, 32'h3, "rst_ctrl");
    rd(RW, 32'h0, "rst_w");
    rd(RL, 32'h0, "rst_l");
    rd(16'h03A8, 32'h0, "unmapped");
    wr(A1, 3);
    wr(A2, 5);
    wr(CT, 1);
    repeat (OP_W + 2) @(negedge clk);
    chk("lat_early_gpio", gpio_out, 0);
    @(negedge clk);
    chk("lat_gpio", gpio_out, 1);
    rd(CT, 32'h3, "t2_ctrl");
    rd(RW, 32'hF, "t2_w");
    rd(RL, 32'h4, "t2_l");
    wr(A1, 32'hFFFFFF);
    wr(A2, 32'hFFFFFF);
    wr(CT, 0);
    repeat (30) @(negedge clk);
    rd(CT, 32'h2, "ovf_ctrl");
`ifdef OVF_SATURATE_EN
    rd(RW, 32'hFFFFFFFF, "ovf_w");
    rd(RL, 32'd32, "ovf_l");
`else
    rd(RW, 32'hFE000001, "ovf_w");
    rd(RL, 32'd8, "ovf_l");
`endif
    chk("ovf_gpio", gpio_out, 2);
    wr(A1, 7);
    wr(A2, 9);
    wr(CT, 1);
    wr(A1, 0);
    wr(CT, 1);
    rd(RW, 32'h0, "busy_w");
    rd(CT, 32'h1, "busy_ctrl");
    repeat (30) @(negedge clk);
    chk("restart_gpio", gpio_out, 3);
    rd(RW, 32'h3F, "snap_w");
    rd(RL, 32'h6, "snap_l");
    rd(A1, 32'h0, "a1_updated");
    wr(A1, 5);
    wr(A2, 32'hFFF);
    wr(CT, 1);
    repeat (10) @(negedge clk);
    n_reset = 0;
    repeat (2) @(negedge clk);
    n_reset = 1;
    @(negedge clk);
    chk("abort_gpio", gpio_out, 0);
    rd(CT, 32'h3, "abort_ctrl");
    rd(RW, 32'h0, "abort_w");
    wr(A1, 2);
    wr(A2, 2);
    wr(CT, 1);
    repeat (30) @(negedge clk);
    rd(RW, 32'h4, "t5_w");
    rd(RL, 32'h1, "t5_l");
    chk("t5_gpio", gpio_out, 1);
    exp_q.push_back(32'h2);
    name_q.push_back("rw_same_pre");
    @(negedge clk);
    saddress = A1;
    sdata_in = 32'h55;
    srd = 1;
    swr = 1;
    @(negedge clk);
    srd = 0;
    swr = 0;
    repeat (2) @(negedge clk);
    rd(A1, 32'h55, "rw_same_post");
    @(negedge clk);
    gpio_in = 32'hA5A5A5A5;
    gpio_latch = 1;
    repeat (2) @(negedge clk);
    gpio_in = 32'h12345678;
    repeat (2) @(negedge clk);
    gpio_latch = 0;
    @(negedge clk);
    chk("latch_once", gpio_in_s_insp, 32'hA5A5A5A5);
    saddress = CT;
    swr = 1;
    repeat (5) @(negedge clk);
    swr = 0;
    repeat (40) @(negedge clk);
    chk("held_swr_gpio", gpio_out, 2);
    rd(CT, 32'h3, "held_swr_ctrl");
    repeat (5) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL pending_reads got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
